align_shift_right: RTL
======================

Name: align_shift_right

Overview:
- Pre-adder alignment stage for the single-precision basic adder. It is the inverse of the post-adder normalization path: it right-shifts, where normalization left-shifts.
- It compares the two operand exponents and swaps the operands so that the larger magnitude is on the A path.
- It right-shifts the smaller mantissa by the exponent difference into the 27-bit guard/round/sticky datapath.
- Its aligned outputs feed the adder and the LZA/normalization logic directly.
- It is a 2-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8, exponent width.
- MANT_W, 24, mantissa width including the hidden bit.
- DP_W, 27, datapath width: MANT_W plus guard, round and sticky bits. Fixed relation: DP_W = MANT_W + 3.
- SH_W, 5, width of the reported shift amount.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input operand pair is valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- sign_a, sign_b  in  1 each  operand signs.
- exp_a, exp_b  in  EXP_W each  operand exponents. These are effective exponents; the caller has already mapped denormals to 1.
- mant_a, mant_b  in  MANT_W each  mantissas with the hidden bit at the MSB.
- out_valid  out  1  output bundle is valid.
- out_ready  in  1  downstream accepts the bundle.
- A  out  DP_W  larger operand: {mant_large, 3'b000}.
- B  out  DP_W  smaller operand, right-shifted, with sticky in bit 0.
- exp_large  out  EXP_W  exponent of the larger operand.
- sign_large, sign_small  out  1 each  signs after the swap.
- shift_right  out  SH_W  applied shift, saturated at 27.
- swapped  out  1  high when operand b was routed to A.

Behaviour:
- Reset, asynchronous while rst_n is low:
  - all stage valid flags = 0, so out_valid = 0;
  - all data registers = 0, so A, B, exp_large, shift_right, swapped and both signs read 0;
  - in_ready = 1 once rst_n deasserts.
  - Reset asserted mid-operation discards all in-flight data. No partial output appears after reset.
- Stage 1 register is loaded when in_valid && in_ready. It computes and stores:
  - swap = (exp_b > exp_a) || (exp_b == exp_a && mant_b > mant_a); equal magnitudes give swap = 0;
  - large and small operands selected by swap;
  - d = exp_large − exp_small, as an unsigned EXP_W-bit value, always ≥ 0;
  - sh = min(d, 27).
- Stage 2 register computes the smaller operand's alignment:
  - X = {mant_small, 3'b000};
  - B = (X >> sh) with bit 0 ORed with the OR of all bits shifted out;
  - for sh = 27: B = {26'b0, |mant_small};
  - for sh = 0: B = X unchanged.
  - A = {mant_large, 3'b000}.
- Latency: 2 cycles from the accepting edge to out_valid, with no stalls. Throughput is 1 bundle per cycle.
- Handshake and flow control:
  - A bundle transfers out on any edge where out_valid && out_ready.
  - Stage 2 advances when it is empty or its bundle transfers this cycle.
  - in_ready = !s1_valid || stage 2 advances.
  - With out_ready held low, at most 2 bundles are held.
  - Outputs stay stable while out_valid && !out_ready. No bundle is ever dropped or duplicated.
- Simultaneous events: accept and emit in the same cycle is legal at full occupancy. The pipeline shifts, and in_ready stays 1.
- in_valid while in_ready = 0: the inputs are ignored, and the source must hold them.
- The block does no rounding and no special-value handling (Inf/NaN/zero). Those are handled upstream and downstream.

Test Plan:
- Basic alignment: exp_a=130, mant_a=24'hC00000, exp_b=128, mant_b=24'h800000 -> 2 cycles later A=27'h6000000, B=27'h1000000, exp_large=130, shift_right=2, swapped=0.
- Sticky saturation: exp_a=160, mant_a=24'h800000, exp_b=130, mant_b=24'h800001 -> B=27'h0000001, shift_right=27. Also exp diff 4 with mant_b=24'h800007 -> B=27'h0400003 (shifted-out bits ORed into bit 0).
- Swap on equal exponents: exp_a=exp_b=127, mant_a=24'h900000, mant_b=24'hA00000, sign_b=1 -> swapped=1, A=27'h5000000, B=27'h4800000, sign_large=1. Exactly equal operands -> swapped=0.
- Backpressure: 3 back-to-back inputs with out_ready=0 -> in_ready=0 after 2 accepts, first bundle held stable. Then out_ready=1 -> bundles emerge in order with no loss, and in_ready returns to 1.
- Streaming: 20 random pairs with in_valid and out_ready held high -> one result per cycle, each matching a reference model, out_valid continuous from cycle 2.
- Reset mid-flight: assert rst_n=0 with 2 bundles in flight -> out_valid=0 and all outputs 0 immediately, with no stale bundle after release.

Source files
------------

// File: rtl/align_shift_right.sv
// align_shift_right: two-stage pre-adder alignment (exponent compare, operand swap, sticky right shift)
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready            operand-pair handshake
//   sign_*, exp_*, mant_*        operand pair (mantissas carry the hidden bit at the MSB)
//   out_valid/out_ready          result handshake
//   A, B                         large operand {mant,3'b0}; small operand aligned with sticky in bit 0
//   exp_large, sign_large/small  exponent and signs after the swap
//   shift_right, swapped         applied shift (saturated at DP_W) and swap flag
module align_shift_right #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24,
  parameter int DP_W   = 27,
  parameter int SH_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DP_W-1:0]   A,
  output logic [DP_W-1:0]   B,
  output logic [EXP_W-1:0]  exp_large,
  output logic              sign_large,
  output logic              sign_small,
  output logic [SH_W-1:0]   shift_right,
  output logic              swapped
);
  logic              s1_valid_q, s1_valid_d;
  logic              s1_swap_q, s1_swap_d;
  logic              s1_sign_l_q, s1_sign_l_d;
  logic              s1_sign_s_q, s1_sign_s_d;
  logic [EXP_W-1:0]  s1_exp_l_q, s1_exp_l_d;
  logic [MANT_W-1:0] s1_mant_l_q, s1_mant_l_d;
  logic [MANT_W-1:0] s1_mant_s_q, s1_mant_s_d;
  logic [SH_W-1:0]   s1_sh_q, s1_sh_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DP_W-1:0]   a_q, a_d;
  logic [DP_W-1:0]   b_q, b_d;
  logic [EXP_W-1:0]  exp_large_q, exp_large_d;
  logic              sign_large_q, sign_large_d;
  logic              sign_small_q, sign_small_d;
  logic [SH_W-1:0]   shift_right_q, shift_right_d;
  logic              swapped_q, swapped_d;
  logic              swap, take, s2_adv, load2;
  logic [EXP_W-1:0]  exp_l, exp_s, diff;
  logic [SH_W-1:0]   sh;
  logic [DP_W-1:0]   x;
  // upper half: shifted operand, lower half: every bit shifted out (feeds sticky)
  logic [2*DP_W-1:0] wide;
  assign s2_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_adv;
  assign take      = in_valid && in_ready;
  assign load2     = s2_adv && s1_valid_q;
  assign out_valid = s2_valid_q;
  assign A           = a_q;
  assign B           = b_q;
  assign exp_large   = exp_large_q;
  assign sign_large  = sign_large_q;
  assign sign_small  = sign_small_q;
  assign shift_right = shift_right_q;
  assign swapped     = swapped_q;
  always_comb begin
    swap        = (exp_b > exp_a) || (exp_b == exp_a && mant_b > mant_a);
    exp_l       = swap ? exp_b : exp_a;
    exp_s       = swap ? exp_a : exp_b;
    diff        = exp_l - exp_s;
    sh          = (diff > EXP_W'(DP_W)) ? SH_W'(DP_W) : SH_W'(diff);
    s1_valid_d  = in_ready ? in_valid : s1_valid_q;
    s1_swap_d   = take ? swap : s1_swap_q;
    s1_sign_l_d = take ? (swap ? sign_b : sign_a) : s1_sign_l_q;
    s1_sign_s_d = take ? (swap ? sign_a : sign_b) : s1_sign_s_q;
    s1_exp_l_d  = take ? exp_l : s1_exp_l_q;
    s1_mant_l_d = take ? (swap ? mant_b : mant_a) : s1_mant_l_q;
    s1_mant_s_d = take ? (swap ? mant_a : mant_b) : s1_mant_s_q;
    s1_sh_d     = take ? sh : s1_sh_q;
  end
  always_comb begin
    x             = {s1_mant_s_q, 3'b000};
    wide          = {x, DP_W'(0)} >> s1_sh_q;
    s2_valid_d    = s2_adv ? s1_valid_q : s2_valid_q;
    a_d           = load2 ? {s1_mant_l_q, 3'b000} : a_q;
    b_d           = load2 ? {wide[2*DP_W-1:DP_W+1], wide[DP_W] | (|wide[DP_W-1:0])} : b_q;
    exp_large_d   = load2 ? s1_exp_l_q : exp_large_q;
    sign_large_d  = load2 ? s1_sign_l_q : sign_large_q;
    sign_small_d  = load2 ? s1_sign_s_q : sign_small_q;
    shift_right_d = load2 ? s1_sh_q : shift_right_q;
    swapped_d     = load2 ? s1_swap_q : swapped_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_swap_q     <= 1'b0;
      s1_sign_l_q   <= 1'b0;
      s1_sign_s_q   <= 1'b0;
      s1_exp_l_q    <= '0;
      s1_mant_l_q   <= '0;
      s1_mant_s_q   <= '0;
      s1_sh_q       <= '0;
      s2_valid_q    <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      exp_large_q   <= '0;
      sign_large_q  <= 1'b0;
      sign_small_q  <= 1'b0;
      shift_right_q <= '0;
      swapped_q     <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_swap_q     <= s1_swap_d;
      s1_sign_l_q   <= s1_sign_l_d;
      s1_sign_s_q   <= s1_sign_s_d;
      s1_exp_l_q    <= s1_exp_l_d;
      s1_mant_l_q   <= s1_mant_l_d;
      s1_mant_s_q   <= s1_mant_s_d;
      s1_sh_q       <= s1_sh_d;
      s2_valid_q    <= s2_valid_d;
      a_q           <= a_d;
      b_q           <= b_d;
      exp_large_q   <= exp_large_d;
      sign_large_q  <= sign_large_d;
      sign_small_q  <= sign_small_d;
      shift_right_q <= shift_right_d;
      swapped_q     <= swapped_d;
    end
  end
endmodule
